// File: rtl/decimal_key_entry_pkg.sv
// Shared types and helpers for the decimal key entry front end.
package key_entry_pkg;

  localparam int DIGIT_W  = 4;
  localparam int NUM_KEYS = 10;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } deb_state_e;

  // Index of the set bit; only meaningful when exactly one bit is set.
  function automatic logic [DIGIT_W-1:0] onehot10_to_bcd(input logic [NUM_KEYS-1:0] v);
    logic [DIGIT_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) r = r | DIGIT_W'(i);
    end
    return r;
  endfunction

  // Number of key lines asserted at once.
  function automatic logic [DIGIT_W-1:0] popcount10(input logic [NUM_KEYS-1:0] v);
    logic [DIGIT_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      r = r + DIGIT_W'(v[i]);
    end
    return r;
  endfunction

endpackage

// File: rtl/decimal_key_entry_if.sv
// Output bus of the key entry block toward the encrypt/decrypt datapath.
//
// Handshake: the master raises code_valid once a full word is assembled and
// then holds code_out and code_valid unchanged until a cycle in which
// code_ready is also high; that cycle is the transfer, and code_valid drops
// on the following cycle. The slave may drive code_ready at any time and
// code_ready has no effect while code_valid is low.
interface decimal_key_entry_if
  import key_entry_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) ();

  logic [DIGIT_W*NUM_DIGITS-1:0] code_out;
  logic                          code_valid;
  logic                          code_ready;
  deb_state_e                    dbg_state;

  modport master (
    output code_out,
    output code_valid,
    output dbg_state,
    input  code_ready
  );

  modport slave (
    input  code_out,
    input  code_valid,
    input  dbg_state,
    output code_ready
  );

endinterface

// File: rtl/decimal_key_entry_debouncer.sv
// Key line synchroniser, press/release debounce FSM and single-key validator.
module key_debouncer
  import key_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic                i_inhibit,
  output logic                key_strobe,
  output logic [DIGIT_W-1:0]  key_code,
  output logic                multi_err,
  output deb_state_e          o_state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_ref;
  logic [CNT_W-1:0]    r_cnt;
  deb_state_e          r_state;
  logic                r_strobe;
  logic [DIGIT_W-1:0]  r_code;
  logic                r_multi;
  logic [DIGIT_W-1:0]  w_pop;

  assign w_pop = popcount10(r_ref);

  // Two-flop synchroniser for the asynchronous key lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM with registered strobe/code/error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ref    <= '0;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_code   <= '0;
      r_multi  <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_multi  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_sync2 != '0) begin
            r_ref   <= r_sync2;
            r_cnt   <= CNT_W'(1);
            r_state <= DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (r_sync2 == '0) begin
            r_state <= IDLE;
          end else if (r_sync2 != r_ref) begin
            r_ref <= r_sync2;
            r_cnt <= CNT_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) r_state <= HELD;
          end
        end
        HELD: begin
          // A full buffer still consumes the press but produces no digit.
          if (w_pop == DIGIT_W'(1)) begin
            if (!i_inhibit) begin
              r_strobe <= 1'b1;
              r_code   <= onehot10_to_bcd(r_ref);
            end
          end else if (w_pop > DIGIT_W'(1)) begin
            r_multi <= 1'b1;
          end
          r_cnt   <= '0;
          r_state <= DEB_RELEASE;
        end
        DEB_RELEASE: begin
          if (r_sync2 != '0) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign key_strobe = r_strobe;
  assign key_code   = r_code;
  assign multi_err  = r_multi;
  assign o_state    = r_state;

endmodule

// File: rtl/decimal_key_entry.sv
// Decimal key entry: debounced keypad digits packed into a BCD word.
module decimal_key_entry
  import key_entry_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_KEYS-1:0]               key_in,
  input  logic                              clear,
  decimal_key_entry_if.master               code_if,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              key_strobe,
  output logic [DIGIT_W-1:0]                key_code,
  output logic                              multi_err
);

  localparam int W  = DIGIT_W * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic [W-1:0]       r_code;
  logic               r_valid;
  logic [CW-1:0]      r_count;
  logic               w_strobe;
  logic [DIGIT_W-1:0] w_key_code;
  logic               w_multi;
  logic [W-1:0]       w_shifted;
  logic               w_accept;
  deb_state_e         w_state;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .i_inhibit  (r_valid),
    .key_strobe (w_strobe),
    .key_code   (w_key_code),
    .multi_err  (w_multi),
    .o_state    (w_state)
  );

  // Newest digit enters at the bottom nibble.
  generate
    if (NUM_DIGITS == 1) begin : g_one
      assign w_shifted = w_key_code;
    end else begin : g_many
      assign w_shifted = {r_code[W-DIGIT_W-1:0], w_key_code};
    end
  endgenerate

  assign w_accept = w_strobe && !r_valid;

  // Accumulator and output handshake; clear beats transfer beats new digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else if (clear) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else if (r_valid && code_if.code_ready) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_code  <= w_shifted;
      r_count <= r_count + CW'(1);
      if (r_count == CW'(NUM_DIGITS - 1)) r_valid <= 1'b1;
    end
  end

  assign code_if.code_out   = r_code;
  assign code_if.code_valid = r_valid;
  assign code_if.dbg_state  = w_state;
  assign digit_count        = r_count;
  assign key_strobe         = w_strobe;
  assign key_code           = w_key_code;
  assign multi_err          = w_multi;

endmodule

// File: tb/tb_decimal_key_entry.sv
// Scoreboard bench for decimal_key_entry with NUM_DIGITS=4, DEBOUNCE_CYCLES=4.
module tb_decimal_key_entry;
  import key_entry_pkg::*;

  localparam int N   = 4;
  localparam int D   = 4;
  localparam int W   = 4 * N;
  localparam int CW  = 3;
  // Edges from driving a stable key to the strobe: 2 sync + D matches + HELD.
  localparam int LAT = D + 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    key_in = '0;
  logic          clear  = 1'b0;
  logic [CW-1:0] digit_count;
  logic          key_strobe;
  logic [3:0]    key_code;
  logic          multi_err;

  decimal_key_entry_if #(.NUM_DIGITS(N)) code_if ();

  decimal_key_entry #(
    .NUM_DIGITS      (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .clear       (clear),
    .code_if     (code_if),
    .digit_count (digit_count),
    .key_strobe  (key_strobe),
    .key_code    (key_code),
    .multi_err   (multi_err)
  );

  // Clock and edge counter.
  always #5 clk = ~clk;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard queues.
  logic [W-1:0] exp_q[$];
  int           exp_key_q[$];
  int           exp_key_edge_q[$];
  int           exp_err_edge_q[$];

  // Reference model: a list of entered digits, kept as a base-16 number.
  int           m_cnt  = 0;
  logic [W-1:0] m_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_word = '0;
  endtask

  task automatic model_digit(input int d);
    if (m_cnt < N) begin
      m_word = W'(m_word * 16 + d);
      m_cnt++;
      if (m_cnt == N) exp_q.push_back(m_word);
    end
  endtask

  // Predict the DUT reaction to a key pattern that becomes stable at edge e0.
  task automatic predict(input logic [9:0] k, input int e0);
    if ($countones(k) == 1) begin
      if (m_cnt < N) begin
        exp_key_q.push_back($clog2(k));
        exp_key_edge_q.push_back(e0 + LAT);
        model_digit($clog2(k));
      end
    end else if ($countones(k) > 1) begin
      exp_err_edge_q.push_back(e0 + LAT);
    end
  endtask

  // Monitor: compares every strobe, error pulse and word transfer.
  int mon_d, mon_e;
  logic [W-1:0] mon_w;
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_strobe) begin
        if (exp_key_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_strobe: got code %0h at edge %0d, expected no strobe", key_code, edge_cnt);
        end else begin
          mon_d = exp_key_q.pop_front();
          mon_e = exp_key_edge_q.pop_front();
          chk("strobe_code", 32'(key_code), 32'(mon_d));
          chk("strobe_edge", 32'(edge_cnt), 32'(mon_e));
        end
      end
      if (multi_err) begin
        if (exp_err_edge_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_multi_err: got pulse at edge %0d, expected none", edge_cnt);
        end else begin
          mon_e = exp_err_edge_q.pop_front();
          chk("multi_err_edge", 32'(edge_cnt), 32'(mon_e));
        end
      end
      if (code_if.code_valid && code_if.code_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %0h, expected no transfer", code_if.code_out);
        end else begin
          mon_w = exp_q.pop_front();
          chk("word", 32'(code_if.code_out), 32'(mon_w));
        end
      end
    end
  end

  // Driver tasks: all input changes happen 1 time unit after a rising edge.
  task automatic release_key();
    #1 key_in = '0;
    repeat (D + 6) @(posedge clk);
  endtask

  task automatic press(input logic [9:0] k, input int hold);
    int e0;
    @(posedge clk);
    #1 key_in = k;
    e0 = edge_cnt;
    predict(k, e0);
    repeat (hold) @(posedge clk);
    release_key();
    chk("digit_count", 32'(digit_count), 32'(m_cnt));
  endtask

  task automatic press_digit(input int d);
    press(10'(1 << d), $urandom_range(LAT + 2, LAT + 10));
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_reset();
    chk("clear_count", 32'(digit_count), 32'd0);
    chk("clear_code", 32'(code_if.code_out), 32'd0);
    chk("clear_valid", 32'(code_if.code_valid), 32'd0);
  endtask

  task automatic accept_word(input int wait_cycles);
    repeat (wait_cycles) @(posedge clk);
    #1 code_if.code_ready = 1'b1;
    @(posedge clk);
    #1 code_if.code_ready = 1'b0;
    model_reset();
    chk("post_xfer_valid", 32'(code_if.code_valid), 32'd0);
    chk("post_xfer_count", 32'(digit_count), 32'd0);
    chk("post_xfer_code", 32'(code_if.code_out), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"}, 32'(digit_count), 32'd0);
    chk({tag, "_strobe"}, 32'(key_strobe), 32'd0);
    chk({tag, "_key_code"}, 32'(key_code), 32'd0);
    chk({tag, "_multi"}, 32'(multi_err), 32'd0);
    chk({tag, "_valid"}, 32'(code_if.code_valid), 32'd0);
    chk({tag, "_code"}, 32'(code_if.code_out), 32'd0);
  endtask

  initial begin
    int e0;
    int a, b;
    code_if.code_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;

    // Clean long press of 7.
    press(10'(1 << 7), 20);
    chk("press7_code", 32'(code_if.code_out), 32'h0007);
    chk("press7_key_code", 32'(key_code), 32'h7);

    // Bouncy press of 3: short runs never reach the debounce length.
    for (int g = 0; g < 3; g++) begin
      @(posedge clk);
      #1 key_in = 10'(1 << 3);
      repeat ($urandom_range(1, D - 1)) @(posedge clk);
      #1 key_in = '0;
      repeat ($urandom_range(0, 1)) @(posedge clk);
    end
    press(10'(1 << 3), 12);
    chk("bounce_code", 32'(code_if.code_out), 32'h0073);

    // Fill the word, hold off the consumer, then transfer.
    do_clear();
    press_digit(1);
    press_digit(9);
    press_digit(0);
    press_digit(5);
    chk("full_valid", 32'(code_if.code_valid), 32'd1);
    chk("full_code", 32'(code_if.code_out), 32'h1905);
    repeat (10) @(posedge clk);
    #1 chk("stall_valid", 32'(code_if.code_valid), 32'd1);
    press_digit(6);
    chk("stall_code", 32'(code_if.code_out), 32'h1905);
    accept_word(0);

    // Two keys together.
    press_digit(4);
    press(10'((1 << 2) | (1 << 8)), 12);

    // Clear coincident with a third strobe.
    do_clear();
    press_digit(2);
    press_digit(7);
    @(posedge clk);
    #1 key_in = 10'(1 << 9);
    e0 = edge_cnt;
    exp_key_q.push_back(9);
    exp_key_edge_q.push_back(e0 + LAT);
    repeat (LAT) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_reset();
    chk("clear_strobe_count", 32'(digit_count), 32'd0);
    chk("clear_strobe_code", 32'(code_if.code_out), 32'd0);
    release_key();
    chk("clear_strobe_after", 32'(digit_count), 32'd0);

    // Reset while a key is mid-debounce, key still held afterwards.
    press_digit(6);
    @(posedge clk);
    #1 key_in = 10'(1 << 4);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    e0 = edge_cnt;
    predict(10'(1 << 4), e0);
    repeat (LAT + 4) @(posedge clk);
    release_key();
    chk("reset_hold_count", 32'(digit_count), 32'(m_cnt));

    // Randomised entries with occasional multi-key presses.
    do_clear();
    for (int e = 0; e < 6; e++) begin
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 4) == 0) begin
          a = $urandom_range(0, 9);
          b = (a + $urandom_range(1, 9)) % 10;
          press(10'((1 << a) | (1 << b)), $urandom_range(LAT + 2, LAT + 8));
        end
        press_digit($urandom_range(0, 9));
      end
      chk("rand_valid", 32'(code_if.code_valid), 32'd1);
      accept_word($urandom_range(0, 5));
    end

    repeat (5) @(posedge clk);
    chk("left_strobes", 32'(exp_key_q.size()), 32'd0);
    chk("left_errs", 32'(exp_err_edge_q.size()), 32'd0);
    chk("left_words", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
